// File: rtl/shift_op_pipe.sv
// shift_op_pipe: registered valid/ready front end for the 16-bit multifunction shifter, with an output FIFO
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_data/in_amt/in_op : request side, op 000 ROTL 001 ROTR 010 SHL 011 SHR 100 ASHR, 101-111 illegal
//   out_valid/out_ready/out_data/out_err   : FIFO head, zeroed while empty
//   level                                  : FIFO occupancy
module shift_op_pipe #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [3:0]       in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_err,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic            s1_valid;
    logic [15:0]     s1_data;
    logic [3:0]      s1_amt;
    logic [2:0]      s1_op;
    logic [15:0]     mem_data [FIFO_DEPTH];
    logic            mem_err  [FIFO_DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [3:0]      r;
    logic [31:0]     dbl;
    logic [15:0]     rot, lo_mask, hi_mask, res;
    logic            res_err, pop;
    // S1 always owns a free FIFO slot, so the push never needs a full check
    assign in_ready  = ({1'b0, level} + (LVL_W+1)'(s1_valid)) < (LVL_W+1)'(FIFO_DEPTH);
    assign out_valid = level != '0;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_data[rp] : '0;
    assign out_err   = out_valid ? mem_err[rp] : 1'b0;
    // every opcode becomes a left rotation; right-going ops rotate by (16-amt) mod 16 and mask the wrapped bits
    always_comb begin
        r       = (s1_op == 3'b000 || s1_op == 3'b010) ? s1_amt : 4'd0 - s1_amt;
        dbl     = {s1_data, s1_data} << r;
        rot     = dbl[31:16];
        lo_mask = (16'd1 << s1_amt) - 16'd1;
        hi_mask = ~(16'hffff >> s1_amt);
        res_err = s1_op > 3'b100;
        res     = res_err            ? s1_data :
                  s1_op == 3'b010    ? rot & ~lo_mask :
                  s1_op == 3'b011    ? rot & ~hi_mask :
                  s1_op == 3'b100    ? (rot & ~hi_mask) | (hi_mask & {16{s1_data[15]}}) :
                                       rot;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_amt   <= '0;
            s1_op    <= '0;
        end else begin
            s1_valid <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                s1_data <= in_data;
                s1_amt  <= in_amt;
                s1_op   <= in_op;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (s1_valid) begin
                mem_data[wp] <= res;
                mem_err[wp]  <= res_err;
                wp           <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            level <= level + LVL_W'(s1_valid) - LVL_W'(pop);
        end
    end
endmodule

// File: tb/tb_shift_op_pipe.sv
// tb_shift_op_pipe: directed and randomized checks of shift_op_pipe against a queue-based reference model
module tb_shift_op_pipe;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
    logic [15:0] in_data = '0, out_data;
    logic [3:0]  in_amt = '0;
    logic [2:0]  in_op = '0;
    logic [2:0]  level;
    int          checks = 0, failures = 0, accepted = 0, delivered = 0, max_lvl = 0;
    logic        m_s1 = 1'b0, acc_last;
    logic [16:0] m_item;
    logic [16:0] fq[$];
    logic [15:0] burst_d [6];

    shift_op_pipe #(.FIFO_DEPTH(DEPTH), .LVL_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_op(logic [15:0] d, int a, logic [2:0] op);
        logic [15:0] x;
        x = d;
        case (op)
            3'd0: for (int i = 0; i < 16; i++) x[i] = d[(i - a + 16) % 16];
            3'd1: for (int i = 0; i < 16; i++) x[i] = d[(i + a) % 16];
            3'd2: x = d << a;
            3'd3: x = d >> a;
            3'd4: x = $signed(d) >>> a;
            default: return {1'b1, d};
        endcase
        return {1'b0, x};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic acc, pop;
        @(negedge clk);
        chk("level", 32'(level), 32'(fq.size()));
        chk("out_valid", 32'(out_valid), 32'(fq.size() != 0));
        chk("in_ready", 32'(in_ready), 32'((fq.size() + int'(m_s1)) < DEPTH));
        chk("out_head", 32'({out_err, out_data}), 32'(fq.size() != 0 ? fq[0] : 17'h0));
        acc = in_valid && ((fq.size() + int'(m_s1)) < DEPTH);
        pop = out_ready && fq.size() != 0;
        @(posedge clk);
        if (pop) begin
            void'(fq.pop_front());
            delivered++;
        end
        if (m_s1) fq.push_back(m_item);
        m_s1 = acc;
        if (acc) begin
            m_item = ref_op(in_data, int'(in_amt), in_op);
            accepted++;
        end
        acc_last = acc;
        if (fq.size() > max_lvl) max_lvl = fq.size();
        #1;
    endtask

    task automatic single(string tag, logic [15:0] d, logic [3:0] a, logic [2:0] op, logic [15:0] ed, logic ee);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = d; in_amt = a; in_op = op;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_err"}, 32'(out_err), 32'(ee));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (fq.size() != 0 || m_s1); i++) tick();
        chk("drain_empty", 32'(fq.size() + int'(m_s1)), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        reset = 1'b0;
        tick();

        single("rotl", 16'h8001, 4'd1, 3'd0, 16'h0003, 1'b0);
        single("rotr", 16'h8001, 4'd1, 3'd1, 16'hC000, 1'b0);
        single("rotr0", 16'h1234, 4'd0, 3'd1, 16'h1234, 1'b0);
        single("shl", 16'h00FF, 4'd4, 3'd2, 16'h0FF0, 1'b0);
        single("shr", 16'hF00F, 4'd4, 3'd3, 16'h0F00, 1'b0);
        single("ashr15", 16'h8000, 4'd15, 3'd4, 16'hFFFF, 1'b0);
        single("ashr14", 16'h4000, 4'd14, 3'd4, 16'h0001, 1'b0);
        single("illegal", 16'h1234, 4'd5, 3'b110, 16'h1234, 1'b1);
        single("after_illegal", 16'h1234, 4'd5, 3'd0, 16'h4682, 1'b0);

        // backpressure: six distinct requests, only four fit
        for (int i = 0; i < 6; i++) burst_d[i] = 16'h1000 + 16'(i * 16'h0111);
        accepted = 0; delivered = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_amt = 4'd0;
        begin
            int idx = 0;
            for (int c = 0; c < 6; c++) begin
                in_data = burst_d[idx];
                in_amt = 4'(idx);
                tick();
                if (acc_last) idx++;
            end
            chk("full_accepted", 32'(accepted), 32'd4);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_level", 32'(level), 32'd4);
            out_ready = 1'b1;
            for (int c = 0; c < 30 && (idx < 6 || fq.size() != 0 || m_s1); c++) begin
                in_valid = idx < 6;
                in_data = burst_d[idx < 6 ? idx : 5];
                in_amt = 4'(idx);
                tick();
                if (acc_last) idx++;
            end
            chk("full_total_accepted", 32'(accepted), 32'd6);
            chk("full_delivered", 32'(delivered), 32'd6);
        end
        in_valid = 1'b0;

        // streaming: one per cycle, FIFO never holds more than one
        max_lvl = 0; delivered = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = 16'($urandom);
            in_amt = 4'($urandom);
            in_op = 3'($urandom_range(0, 4));
            tick();
            chk("stream_accept", 32'(acc_last), 32'd1);
        end
        drain();
        chk("stream_max_level", 32'(max_lvl), 32'd1);
        chk("stream_delivered", 32'(delivered), 32'd8);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            in_data = 16'($urandom);
            in_amt = 4'($urandom);
            in_op = 3'($urandom_range(0, 7));
            tick();
        end
        drain();

        // reset with three queued and one in S1
        out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd2;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'hA5A0 + 16'(i);
            in_amt = 4'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_err", 32'(out_err), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        fq.delete();
        m_s1 = 1'b0;
        #1 reset = 1'b0;
        delivered = 0;
        single("post_rst", 16'h0001, 4'd3, 3'd0, 16'h0008, 1'b0);
        repeat (3) tick();
        chk("post_rst_delivered", 32'(delivered), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
